hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core: generates EX-stage operand forwarding selects, ID-stage write-back bypass, load-use stalls, multi-cycle multiply holds and branch/jump flushes, plus saturating stall/flush performance counters. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold/flush inputs and the two EX operand muxes.

## Interface
- REG_ADDR_W, 5, register address width
- MUL_LAT, 3, EX-stage occupancy of a multiply in cycles (≥1; 1 = no hold)
- BR_RESOLVE_MEM, 1, 1: redirect is resolved in MEM (flush 3 stages); 0: resolved in EX (flush 2)
- CNT_W, 16, performance counter width
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  pipeline enable; 0 freezes all internal state
- id_rs1, id_rs2  in  REG_ADDR_W  source regs of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source
- ex_rs1, ex_rs2, ex_rd  in  REG_ADDR_W  regs of instruction in EX
- ex_reg_write, ex_mem_read, ex_is_mul  in  1  EX control bits
- mem_rd  in  REG_ADDR_W; mem_reg_write  in  1  EX/MEM destination
- wb_rd  in  REG_ADDR_W; wb_reg_write  in  1  MEM/WB destination
- redirect  in  1  taken branch/jump resolved this cycle
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM alu_out, 01 MEM/WB write data
- id_byp_a, id_byp_b  out  1  ID read data replaced by MEM/WB write data
- stall_pc, stall_if_id, stall_id_ex  out  1  hold register
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  register loads bubble (all control bits 0)
- mul_busy  out  1  FSM in BUSY; mul_done  out  1  final multiply cycle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Register x0 never matches: any rd==0 disables forwarding, bypass and load-use.
- Forwarding (combinational): fwd_a=10 if mem_reg_write & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd==ex_rs1; else 00. EX/MEM has priority. fwd_b identical on ex_rs2.
- id_byp_a = wb_reg_write & wb_rd==id_rs1 (same for b).
- Load-use: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)) → stall_pc, stall_if_id, flush_id_ex for one cycle.
- Multiply FSM, states IDLE/BUSY, down-counter cnt:
  - IDLE & ex_is_mul & MUL_LAT>1: hold asserted this cycle; next BUSY, cnt=MUL_LAT-2.
  - BUSY & cnt!=0: hold; cnt-1.
  - BUSY & cnt==0: no hold, mul_done=1; next IDLE.
  - MUL_LAT==1: FSM stays IDLE, mul_done=ex_is_mul.
  - hold = stall_pc, stall_if_id, stall_id_ex, flush_ex_mem.
- Redirect: stall_* forced 0; flush_if_id=flush_id_ex=1; flush_ex_mem=BR_RESOLVE_MEM. If BR_RESOLVE_MEM=1 the EX instruction is killed: FSM → IDLE, no mul_done.
- Priority: redirect > multiply hold > load-use.
- Counters: stall_cnt +1 per enabled cycle with stall_pc; flush_cnt +1 per enabled cycle with redirect; saturate at all-ones.
- en=0: FSM, cnt, counters unchanged; combinational outputs still valid.

## Timing
- Forward, bypass, stall and flush outputs combinational from inputs and FSM state; zero latency.
- FSM, cnt and counters update on rising clk when en=1.
- rst (sync): state IDLE, cnt=0, stall_cnt=flush_cnt=0, mul_busy=0, mul_done=0; combinational outputs follow inputs. Reset mid-multiply aborts it; the following cycle is IDLE.
- Multiply with MUL_LAT=N holds the pipeline N-1 cycles; EX occupied N cycles. Back-to-back multiplies: the second starts in the cycle after mul_done.

## Test plan
- EX/MEM and MEM/WB both write x5, EX reads x5 as rs1 → fwd_a=10; EX/MEM rd=0 with MEM/WB rd=5 → fwd_a=01; all rd=0 → 00.
- Load to x7 in EX, ID uses x7 as rs2 → stall_pc/stall_if_id/flush_id_ex high exactly 1 cycle, stall_cnt=1; same with id_uses_rs2=0 → no stall.
- MUL_LAT=3, ex_is_mul one instruction → hold 2 cycles, mul_done in 3rd, mul_busy high cycles 2–3; MUL_LAT=1 → no hold.
- redirect during BUSY with BR_RESOLVE_MEM=1 → three flushes, stalls 0, FSM IDLE next cycle, no mul_done, flush_cnt+1; BR_RESOLVE_MEM=0 → flush_ex_mem=0.
- rst asserted in BUSY → IDLE, counters 0 next cycle; en=0 during BUSY → cnt frozen, completion delayed by same cycles.
- CNT_W=2, 5 load-use stalls → stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl_unit.
// The datapath side uses the master modport; the hazard unit uses the slave modport.
`timescale 1ns/1ps
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) ();
    logic                  en;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_is_mul;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  redirect;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  id_byp_a;
    logic                  id_byp_b;
    logic                  stall_pc;
    logic                  stall_if_id;
    logic                  stall_id_ex;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  flush_ex_mem;
    logic                  mul_busy;
    logic                  mul_done;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output en, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, redirect,
        input  fwd_a, fwd_b, id_byp_a, id_byp_b,
               stall_pc, stall_if_id, stall_id_ex,
               flush_if_id, flush_id_ex, flush_ex_mem,
               mul_busy, mul_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  en, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, redirect,
        output fwd_a, fwd_b, id_byp_a, id_byp_b,
               stall_pc, stall_if_id, stall_id_ex,
               flush_if_id, flush_id_ex, flush_ex_mem,
               mul_busy, mul_done, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: forwarding, WB bypass, load-use stall,
// multi-cycle multiply hold, redirect flush and saturating stall/flush counters.
`timescale 1ns/1ps
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned MUL_LAT        = 3,
    parameter bit          BR_RESOLVE_MEM = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave hif
);
    localparam int unsigned CNT_BITS = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = (MUL_LAT > 1) ? CNT_BITS'(MUL_LAT - 2) : '0;
    localparam bit                  SINGLE_CYCLE_MUL = (MUL_LAT <= 1);
    localparam logic [REG_ADDR_W-1:0] X0      = '0;
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       load_use;
    logic       mul_start;
    logic       mul_hold;
    logic       kill_ex;
    logic       mul_done;
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hif.mem_reg_write && hif.mem_rd != X0 && hif.mem_rd == hif.ex_rs1)
            fwd_a = 2'b10;
        else if (hif.wb_reg_write && hif.wb_rd != X0 && hif.wb_rd == hif.ex_rs1)
            fwd_a = 2'b01;
        if (hif.mem_reg_write && hif.mem_rd != X0 && hif.mem_rd == hif.ex_rs2)
            fwd_b = 2'b10;
        else if (hif.wb_reg_write && hif.wb_rd != X0 && hif.wb_rd == hif.ex_rs2)
            fwd_b = 2'b01;
    end

    assign hif.id_byp_a = hif.wb_reg_write && hif.wb_rd != X0 && hif.wb_rd == hif.id_rs1;
    assign hif.id_byp_b = hif.wb_reg_write && hif.wb_rd != X0 && hif.wb_rd == hif.id_rs2;

    assign load_use = hif.ex_mem_read && hif.ex_rd != X0 &&
                      ((hif.id_uses_rs1 && hif.ex_rd == hif.id_rs1) ||
                       (hif.id_uses_rs2 && hif.ex_rd == hif.id_rs2));

    // A redirect resolved in MEM kills the instruction in EX, multiply included.
    assign kill_ex   = hif.redirect && BR_RESOLVE_MEM;
    assign mul_start = !SINGLE_CYCLE_MUL && state == IDLE && hif.ex_is_mul;
    assign mul_hold  = mul_start || (state == BUSY && cnt != '0);
    assign mul_done  = !kill_ex && (SINGLE_CYCLE_MUL ? hif.ex_is_mul
                                                     : (state == BUSY && cnt == '0));

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (hif.redirect) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = BR_RESOLVE_MEM;
        end else if (mul_hold) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hif.en) begin
            if (stall_pc && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (hif.redirect && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (mul_start && !kill_ex) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (kill_ex || cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign hif.fwd_a        = fwd_a;
    assign hif.fwd_b        = fwd_b;
    assign hif.stall_pc     = stall_pc;
    assign hif.stall_if_id  = stall_if_id;
    assign hif.stall_id_ex  = stall_id_ex;
    assign hif.flush_if_id  = flush_if_id;
    assign hif.flush_id_ex  = flush_id_ex;
    assign hif.flush_ex_mem = flush_ex_mem;
    assign hif.mul_busy     = (state == BUSY);
    assign hif.mul_done     = mul_done;
    assign hif.stall_cnt    = stall_cnt;
    assign hif.flush_cnt    = flush_cnt;
endmodule
